// File: rtl/or1k_spr_pkg.sv
// Shared SPR bus definitions: field widths, the master FSM state type and
// address decode helpers that responders use instead of local offset macros.
package or1k_spr_pkg;

  localparam int SPR_GROUP_W  = 5;
  localparam int SPR_OFFSET_W = 11;
  localparam int SPR_ADDR_W   = 16;
  localparam int SPR_DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } spr_master_state_t;

  // Group number lives in the top bits of the SPR address
  function automatic logic [SPR_GROUP_W-1:0] spr_group(input logic [SPR_ADDR_W-1:0] addr);
    return addr[SPR_ADDR_W-1 -: SPR_GROUP_W];
  endfunction

  // Register offset within the group
  function automatic logic [SPR_OFFSET_W-1:0] spr_offset(input logic [SPR_ADDR_W-1:0] addr);
    return addr[SPR_OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/or1k_spr_bus_master.sv
// SPR bus initiator: accepts one mtspr/mfspr request at a time, runs it on
// the SPR bus until the responder acks (or the timeout expires) and hands
// the result back over a valid/ready response channel.
module or1k_spr_bus_master
  import or1k_spr_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [SPR_ADDR_W-1:0] req_addr_i,
  input  logic [SPR_DATA_W-1:0] req_dat_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [SPR_DATA_W-1:0] rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  spr_access_o,
  output logic                  spr_we_o,
  output logic [SPR_ADDR_W-1:0] spr_addr_o,
  output logic [SPR_DATA_W-1:0] spr_dat_o,
  input  logic                  spr_bus_ack_i,
  input  logic [SPR_DATA_W-1:0] spr_dat_i
);

  // A zero timeout still needs a 1-bit counter so the saturation logic stays legal
  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  spr_master_state_t     state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  we_reg;
  logic [SPR_ADDR_W-1:0] addr_reg;
  logic [SPR_DATA_W-1:0] dat_reg;
  logic [SPR_DATA_W-1:0] rsp_dat_reg;
  logic                  rsp_err_reg;

  // Transaction FSM: latch the request, wait for ack or timeout, hold the response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      dat_reg     <= '0;
      rsp_dat_reg <= '0;
      rsp_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // req_ready_o is high in IDLE, so valid alone completes the handshake
          if (req_valid_i) begin
            we_reg      <= req_we_i;
            addr_reg    <= req_addr_i;
            dat_reg     <= req_dat_i;
            cnt_reg     <= '0;
            rsp_dat_reg <= '0;
            rsp_err_reg <= 1'b0;
            state_reg   <= ACCESS;
          end
        end
        ACCESS: begin
          // Ack has priority over an expiring timeout in the same cycle
          if (spr_bus_ack_i) begin
            rsp_dat_reg <= we_reg ? '0 : spr_dat_i;
            rsp_err_reg <= 1'b0;
            state_reg   <= RESP;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_reg == CNT_LAST)) begin
            rsp_dat_reg <= '0;
            rsp_err_reg <= 1'b1;
            state_reg   <= RESP;
          end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outputs decode from state and latched registers only; no input reaches an output
  always_comb begin
    req_ready_o  = (state_reg == IDLE);
    spr_access_o = (state_reg == ACCESS);
    spr_we_o     = spr_access_o & we_reg;
    spr_addr_o   = spr_access_o ? addr_reg : '0;
    spr_dat_o    = (spr_access_o && we_reg) ? dat_reg : '0;
    rsp_valid_o  = (state_reg == RESP);
    rsp_dat_o    = rsp_valid_o ? rsp_dat_reg : '0;
    rsp_err_o    = rsp_valid_o & rsp_err_reg;
  end

endmodule
